vga_timing: RTL

Raster timing generator for the 800x600@60 Hz VGA output path; it sits directly upstream of the colour-bar / pixel-colour stages. It produces the horizontal pixel counter COLUMNA consumed by `barras_rgb`, plus the line counter FILA, the sync pulses, and the DAC blanking/sync strobes. Count 0 is the first clock of the sync pulse, so the first visible column is COLUMNA = H_SYNC + H_BACK = 216.

---
 rtl/vga_pkg.sv | 64 ++++++
 rtl/vga_axis_counter.sv | 82 ++++++++
 rtl/vga_timing.sv | 71 +++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared 800x600@60 raster constants and phase encoding.
// Used by the axis counters and the vga_timing top.
package vga_pkg;

  localparam int CW = 11;

  localparam int H_SYNC   = 128;
  localparam int H_BACK   = 88;
  localparam int H_ACTIVE = 800;
  localparam int H_FRONT  = 40;
  localparam int V_SYNC   = 4;
  localparam int V_BACK   = 23;
  localparam int V_ACTIVE = 600;
  localparam int V_FRONT  = 1;
  localparam bit H_POL    = 1'b1;
  localparam bit V_POL    = 1'b1;

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  typedef enum logic [1:0] {
    SYNC_S  = 2'd0,
    BACK_S  = 2'd1,
    ACT_S   = 2'd2,
    FRONT_S = 2'd3
  } phase_t;

  function automatic logic [CW-1:0] phase_last(
    input int     s,
    input int     b,
    input int     a,
    input int     f,
    input phase_t p
  );
    int v;
    v = 0;
    unique case (p)
      SYNC_S:  v = s - 1;
      BACK_S:  v = s + b - 1;
      ACT_S:   v = s + b + a - 1;
      default: v = s + b + a + f - 1;
    endcase
    return CW'(v);
  endfunction

  localparam logic [CW-1:0] H_SYNC_LAST  =
    phase_last(H_SYNC, H_BACK, H_ACTIVE, H_FRONT, SYNC_S);
  localparam logic [CW-1:0] H_BACK_LAST  =
    phase_last(H_SYNC, H_BACK, H_ACTIVE, H_FRONT, BACK_S);
  localparam logic [CW-1:0] H_ACT_LAST   =
    phase_last(H_SYNC, H_BACK, H_ACTIVE, H_FRONT, ACT_S);
  localparam logic [CW-1:0] H_FRONT_LAST =
    phase_last(H_SYNC, H_BACK, H_ACTIVE, H_FRONT, FRONT_S);

  localparam logic [CW-1:0] V_SYNC_LAST  =
    phase_last(V_SYNC, V_BACK, V_ACTIVE, V_FRONT, SYNC_S);
  localparam logic [CW-1:0] V_BACK_LAST  =
    phase_last(V_SYNC, V_BACK, V_ACTIVE, V_FRONT, BACK_S);
  localparam logic [CW-1:0] V_ACT_LAST   =
    phase_last(V_SYNC, V_BACK, V_ACTIVE, V_FRONT, ACT_S);
  localparam logic [CW-1:0] V_FRONT_LAST =
    phase_last(V_SYNC, V_BACK, V_ACTIVE, V_FRONT, FRONT_S);

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis - counter, phase FSM,
// registered sync/active decode and terminal-count strobe.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int SYNC   = 128,
  parameter int BACK   = 88,
  parameter int ACTIVE = 800,
  parameter int FRONT  = 40,
  parameter bit POL    = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          sync,
  output logic          act,
  output logic          tc
);

  localparam logic [CW-1:0] L_SYNC  =
    phase_last(SYNC, BACK, ACTIVE, FRONT, SYNC_S);
  localparam logic [CW-1:0] L_BACK  =
    phase_last(SYNC, BACK, ACTIVE, FRONT, BACK_S);
  localparam logic [CW-1:0] L_ACT   =
    phase_last(SYNC, BACK, ACTIVE, FRONT, ACT_S);
  localparam logic [CW-1:0] L_FRONT =
    phase_last(SYNC, BACK, ACTIVE, FRONT, FRONT_S);

  phase_t        state_q;
  phase_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] last;
  logic          sync_q;
  logic          act_q;

  always_comb begin
    last    = L_FRONT;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SYNC_S:  last = L_SYNC;
      BACK_S:  last = L_BACK;
      ACT_S:   last = L_ACT;
      FRONT_S: last = L_FRONT;
    endcase
    if (en) begin
      cnt_d = (cnt_q == L_FRONT) ? '0 : cnt_q + CW'(1);
      if (cnt_q == last) begin
        unique case (state_q)
          SYNC_S:  state_d = BACK_S;
          BACK_S:  state_d = ACT_S;
          ACT_S:   state_d = FRONT_S;
          FRONT_S: state_d = SYNC_S;
        endcase
      end
    end
  end

  // sync/act are registered from the next phase so they line up
  // with the count they describe on every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SYNC_S;
      cnt_q   <= '0;
      sync_q  <= POL;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= (state_d == SYNC_S) ? POL : ~POL;
      act_q   <= (state_d == ACT_S);
    end
  end

  assign count = cnt_q;
  assign sync  = sync_q;
  assign act   = act_q;
  assign tc    = en & (cnt_q == L_FRONT);

endmodule

// File: rtl/vga_timing.sv
// vga_timing: 800x600@60 raster generator driving COLUMNA/FILA,
// sync pulses and the DAC blank/sync strobes.
module vga_timing #(
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BACK   = vga_pkg::H_BACK,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FRONT  = vga_pkg::H_FRONT,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BACK   = vga_pkg::V_BACK,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FRONT  = vga_pkg::V_FRONT,
  parameter bit H_POL    = vga_pkg::H_POL,
  parameter bit V_POL    = vga_pkg::V_POL
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  output logic [10:0] COLUMNA,
  output logic [10:0] FILA,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        BLANK_n,
  output logic        SYNC_n,
  output logic        LINE_END,
  output logic        FRAME_END
);

  logic h_act;
  logic v_act;
  logic h_tc;
  logic v_tc;

  vga_axis_counter #(
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .POL    (H_POL)
  ) u_h (
    .clk   (CLK),
    .rst   (RESET),
    .en    (CE),
    .count (COLUMNA),
    .sync  (HSYNC),
    .act   (h_act),
    .tc    (h_tc)
  );

  // vertical axis steps once per line, on the horizontal wrap
  vga_axis_counter #(
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .POL    (V_POL)
  ) u_v (
    .clk   (CLK),
    .rst   (RESET),
    .en    (h_tc),
    .count (FILA),
    .sync  (VSYNC),
    .act   (v_act),
    .tc    (v_tc)
  );

  assign BLANK_n   = h_act & v_act;
  assign SYNC_n    = 1'b0;
  assign LINE_END  = h_tc;
  assign FRAME_END = v_tc;

endmodule
